// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the core data bus.
// Software pushes bytes through TXDATA into a circular FIFO, and a shifter
// FSM serialises them LSB first, running frames back to back.
// Bus reads are combinational so the MEM stage sees them in the same cycle.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_we,
  output logic [31:0] bus_rdata,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Control / status registers
  logic [15:0]   div;
  logic          irq_en;
  logic          overflow;
  logic          wr;
  logic [1:0]    sel;

  // Shifter state
  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [15:0]   baud_cnt;
  logic [15:0]   frame_div;
  logic          baud_end;
  logic          busy;
  logic [31:0]   status;

  logic          unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:17]};

  assign hit   = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign wr    = hit & bus_we;
  assign sel   = bus_addr[3:2];
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Full is judged before any same-cycle pop, so a write into a full FIFO is
  // dropped even when the shifter frees a slot on that edge.
  assign push     = wr && (sel == 2'd0) && !full;
  assign baud_end = (baud_cnt == frame_div - 16'd1);
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && baud_end));
  assign busy     = (state != IDLE) || !empty;

  assign status = {19'b0, 5'(count), 4'b0, overflow, empty, full, busy};

  // Combinational register read mux
  always_comb begin
    bus_rdata = '0;
    if (hit) begin
      case (sel)
        2'd1:    bus_rdata = status;
        2'd2:    bus_rdata = {15'b0, irq_en, div};
        default: bus_rdata = '0;
      endcase
    end
  end

  // FIFO data array (no reset needed; occupancy is tracked by count)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus_wdata[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // CTRL and sticky OVERFLOW register writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= DEFAULT_DIV;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else if (wr) begin
      case (sel)
        2'd0: begin
          if (full) begin
            overflow <= 1'b1;
          end
        end
        2'd2: begin
          div    <= (bus_wdata[15:0] == 16'd0) ? 16'd1 : bus_wdata[15:0];
          irq_en <= bus_wdata[16];
        end
        2'd3: begin
          if (bus_wdata[3]) begin
            overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Idle interrupt, registered one clock behind its conditions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_en && empty && (state == IDLE);
    end
  end

  // Shifter FSM; tx is registered from the current state, one clock behind it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      baud_cnt  <= '0;
      frame_div <= 16'd1;
      tx        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift     <= mem[rd_ptr];
            frame_div <= div;
            baud_cnt  <= '0;
            state     <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          tx <= shift[0];
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift     <= mem[rd_ptr];
              frame_div <= div;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio.
module tb_uart_tx_mmio;

  localparam logic [31:0] TXD  = 32'h1000_0000;
  localparam logic [31:0] STAT = 32'h1000_0004;
  localparam logic [31:0] CTRL = 32'h1000_0008;
  localparam logic [31:0] CLR  = 32'h1000_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        hit;
  logic        tx;
  logic        irq;

  int errors = 0;
  int checks = 0;

  logic [7:0] burst [10];

  uart_tx_mmio #(
    .BASE_ADDR(32'h1000_0000),
    .FIFO_DEPTH(8),
    .DEFAULT_DIV(16'd868)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_we(bus_we),
    .bus_rdata(bus_rdata),
    .hit(hit),
    .tx(tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    @(posedge clk);
    #1;
    bus_we    = 1'b0;
    bus_addr  = 32'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_addr = a;
    bus_we   = 1'b0;
    #1;
    chk(tag, bus_rdata, exp);
  endtask

  // Expected line level at offset j (clocks) into an 8N1 frame
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned div,
                                     input int unsigned j);
    int unsigned b;
    b = j / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[3'(b - 1)];
    return 1'b1;
  endfunction

  // Write one byte from idle and check the full waveform plus irq drop
  task automatic send_frame(input string tag, input logic [7:0] d,
                            input int unsigned div, input logic irq0);
    bus_write(TXD, {24'h0, d});
    chk({tag, "_tx_e0"}, {31'h0, tx}, 32'h1);
    chk({tag, "_irq_e0"}, {31'h0, irq}, {31'h0, irq0});
    tick;
    chk({tag, "_tx_e1"}, {31'h0, tx}, 32'h1);
    chk({tag, "_irq_e1"}, {31'h0, irq}, 32'h0);
    for (int unsigned j = 0; j < 10 * div; j++) begin
      tick;
      chk($sformatf("%s_tx[%0d]", tag, j), {31'h0, tx}, {31'h0, frame_bit(d, div, j)});
    end
  endtask

  initial begin
    logic e;
    int   jj;

    reset     = 1'b1;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_we    = 1'b0;
    for (int i = 0; i < 10; i++) burst[i] = 8'(i * 29 + 8'h5A);

    // Reset state
    #1;
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("rst_status_in_reset", STAT, 32'h0000_0004);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_chk("rst_status", STAT, 32'h0000_0004);
    rd_chk("rst_ctrl", CTRL, 32'h0000_0364);
    rd_chk("rst_txdata", TXD, 32'h0);
    rd_chk("rst_clear", CLR, 32'h0);
    bus_addr = CLR;
    #1;
    chk("hit_in", {31'h0, hit}, 32'h1);
    bus_addr = 32'h1000_0010;
    #1;
    chk("hit_out", {31'h0, hit}, 32'h0);

    // Single 0x55 frame at DIV=4
    bus_write(CTRL, 32'd4);
    rd_chk("t1_ctrl", CTRL, 32'h0000_0004);
    send_frame("f55", 8'h55, 4, 1'b0);
    rd_chk("t1_status_idle", STAT, 32'h0000_0004);
    tick;
    chk("t1_tx_after", {31'h0, tx}, 32'h1);

    // Ten consecutive writes: one popped, eight queued, one dropped
    for (int k = 0; k < 370; k++) begin
      if (k < 10) begin
        bus_addr  = TXD;
        bus_wdata = {24'h0, burst[k]};
        bus_we    = 1'b1;
      end else if (k == 10) begin
        bus_we   = 1'b0;
        bus_addr = STAT;
        #1;
        chk("burst_status", bus_rdata, 32'h0000_080B);
      end else begin
        bus_we   = 1'b0;
        bus_addr = 32'h0;
      end
      tick;
      jj = k - 2;
      if (k < 2) e = 1'b1;
      else if (jj < 360) e = frame_bit(burst[jj / 40], 4, 32'(jj % 40));
      else e = 1'b1;
      chk($sformatf("burst_tx[%0d]", k), {31'h0, tx}, {31'h0, e});
    end
    rd_chk("burst_status_end", STAT, 32'h0000_000C);

    // OVERFLOW clears only through CLEAR
    bus_write(STAT, 32'h8);
    rd_chk("ovf_after_status_wr", STAT, 32'h0000_000C);
    bus_write(CLR, 32'h8);
    rd_chk("ovf_after_clear", STAT, 32'h0000_0004);

    // DIV clamp and idle interrupt
    bus_write(CTRL, 32'h0001_0000);
    rd_chk("irq_ctrl_clamp", CTRL, 32'h0001_0001);
    chk("irq_e0", {31'h0, irq}, 32'h0);
    tick;
    chk("irq_e1", {31'h0, irq}, 32'h1);
    send_frame("f3c", 8'h3C, 1, 1'b1);
    chk("irq_frame_end", {31'h0, irq}, 32'h0);
    tick;
    chk("irq_reassert", {31'h0, irq}, 32'h1);
    rd_chk("irq_status", STAT, 32'h0000_0004);

    // DIV change mid-frame only affects the following frame
    bus_write(CTRL, 32'd8);
    for (int k = 0; k < 110; k++) begin
      bus_we   = 1'b0;
      bus_addr = 32'h0;
      if (k == 0) begin
        bus_addr = TXD; bus_wdata = 32'hA5; bus_we = 1'b1;
      end else if (k == 1) begin
        bus_addr = TXD; bus_wdata = 32'h5A; bus_we = 1'b1;
      end else if (k == 20) begin
        bus_addr = CTRL; bus_wdata = 32'd2; bus_we = 1'b1;
      end
      tick;
      jj = k - 2;
      if (k < 2) e = 1'b1;
      else if (jj < 80) e = frame_bit(8'hA5, 8, 32'(jj));
      else if (jj < 100) e = frame_bit(8'h5A, 2, 32'(jj - 80));
      else e = 1'b1;
      chk($sformatf("divchg_tx[%0d]", k), {31'h0, tx}, {31'h0, e});
    end
    bus_we = 1'b0;
    rd_chk("divchg_ctrl", CTRL, 32'h0000_0002);
    rd_chk("divchg_status", STAT, 32'h0000_0004);

    // Asynchronous reset in the middle of a data bit
    bus_write(CTRL, 32'd8);
    bus_write(TXD, 32'h00);
    bus_write(TXD, 32'h00);
    repeat (12) tick;
    chk("mid_tx_low", {31'h0, tx}, 32'h0);
    rd_chk("mid_status", STAT, 32'h0000_0101);
    #1;
    reset = 1'b1;
    #1;
    chk("async_tx", {31'h0, tx}, 32'h1);
    chk("async_irq", {31'h0, irq}, 32'h0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    rd_chk("post_rst_status", STAT, 32'h0000_0004);
    rd_chk("post_rst_ctrl", CTRL, 32'h0000_0364);
    bus_addr = 32'h0;
    for (int k = 0; k < 60; k++) begin
      tick;
      chk($sformatf("post_rst_tx[%0d]", k), {31'h0, tx}, 32'h1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that sits downstream of the core's data-memory port in the SoC top. It shares the core's `ram_addr` / `ram_wdata` / `ram_we` bus alongside data RAM and returns read data on the same-cycle read path the MEM stage expects. Bytes written by software are queued in a FIFO and serialised as 8N1 frames, LSB first, on `tx`.

## Interface

Parameters:
- `BASE_ADDR`, default 32'h1000_0000: block base address; 16-byte window.
- `FIFO_DEPTH`, default 8: TX FIFO entries, power of two, 2..16.
- `DEFAULT_DIV`, default 16'd868: clocks per bit after reset.

Ports:
- `clk`  in  1: single clock. All state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high.
- `bus_addr`  in  32: core `ram_addr`.
- `bus_wdata`  in  32: core `ram_wdata`.
- `bus_we`  in  1: core `ram_we`.
- `bus_rdata`  out  32: read data, combinational from `bus_addr`. The SoC muxes it onto `ram_rdata` when `hit` is 1.
- `hit`  out  1: `bus_addr[31:4] == BASE_ADDR[31:4]`, combinational.
- `tx`  out  1: serial output, idle high.
- `irq`  out  1: registered; 1 when IRQ enable is set and the FIFO is empty and the shifter is idle.

## Operation

Register map, selected by `bus_addr[3:2]`. A write takes effect at the clock edge where `hit & bus_we` is 1.
- 0x0 TXDATA
  - Write pushes `bus_wdata[7:0]`.
  - If the FIFO is full, the write is dropped and OVERFLOW is set.
  - Reads return 0.
- 0x4 STATUS, read-only:
  - bit0 BUSY = shifter not IDLE or FIFO not empty.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVERFLOW (sticky).
  - bits[12:8] COUNT (FIFO occupancy).
  - Other bits read 0. Writes are ignored.
- 0x8 CTRL, read/write:
  - bits[15:0] DIV.
  - bit16 IRQ_EN.
  - Writing DIV=0 stores 1.
- 0xC CLEAR: writing bit3=1 clears OVERFLOW. Reads return 0.

FIFO:
- Circular buffer with wrapping read/write pointers and a COUNT register.
- FULL is evaluated before any same-cycle pop. A push while full is dropped, even if a pop occurs in the same cycle.
- A push and a pop in the same cycle with the FIFO not full: both happen and COUNT is unchanged.

Shifter FSM:
- States IDLE, START, DATA, STOP. Registers: 8-bit shift register, 3-bit bit index, 16-bit baud counter, 16-bit `frame_div`.
- `frame_div` latches DIV when a frame starts. A CTRL write during a frame only affects later frames.
- IDLE, FIFO not empty: pop the head byte into the shift register, load `frame_div`, clear the baud counter, go to START.
- START: `tx`=0 for `frame_div` clocks, then go to DATA with bit index 0.
- DATA: `tx`=`shift[0]` for `frame_div` clocks, then shift right and increment the bit index. After bit 7, go to STOP.
- STOP: `tx`=1 for `frame_div` clocks.
  - At the end of STOP with the FIFO not empty: pop and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- `tx` is a registered output. It is 1 in IDLE and STOP.

Reset (asynchronous, effective immediately, including mid-frame):
- `tx`=1, FSM IDLE, FIFO empty, pointers and COUNT 0.
- OVERFLOW=0, DIV=`DEFAULT_DIV`, IRQ_EN=0, `irq`=0.
- `bus_rdata` reflects the reset register values.

## Timing

- Write-to-visible: a register written at edge E reads back the new value in the cycle after E.
- TXDATA written at edge E0 with the FSM IDLE and the FIFO empty:
  - E1 pops the byte and enters START.
  - `tx` falls after E2, because `tx` is registered one cycle behind the state.
  - Latency from write to start bit is 2 clocks.
- Frame length: exactly 10 × `frame_div` clocks.
- Back-to-back frames: the stop-bit high of one frame is followed immediately by the next start bit.
- `bus_rdata` and `hit` are combinational with zero latency. The core registers them in MEM/WB.
- `irq` updates one clock after its conditions change.

## Test plan

- Reset, DIV=4, write 0x55 to TXDATA → `tx` stays high 2 clocks, then:
  - low 4 clocks (start bit);
  - data bits 1,0,1,0,1,0,1,0, each 4 clocks;
  - high 4 clocks (stop bit).
  - BUSY reads 0 after the frame.
- DIV=4, write 10 bytes to TXDATA on consecutive cycles starting from idle:
  - byte0 is popped at once, bytes 1..8 fill the FIFO, byte9 is dropped;
  - STATUS reads 0x0000080B (COUNT=8, OVERFLOW, FULL, BUSY);
  - `tx` emits bytes 0..8 back-to-back with no gap, 360 clocks total.
- With OVERFLOW set, write 0x8 to CLEAR → STATUS bit3=0 on the next read. Writing 0x8 to STATUS does not clear it.
- Write CTRL=0x0001_0000 → CTRL reads 0x0001_0001 (DIV clamped to 1). `irq`=1 one clock later while idle. `irq` drops one clock after a TXDATA write.
- Start a frame with DIV=8, then write DIV=2 mid-frame → the current frame keeps 8 clocks per bit, the next frame uses 2.
- Assert `reset` mid-DATA → `tx`=1 immediately (asynchronous). After deassertion, FIFO empty, DIV=868, and no residual frame is emitted.
